// File: rtl/dog_builder.sv
// Difference-of-Gaussians builder: streams two adjacent blur levels from the pyramid BRAM
// and writes B - A per pixel to the DoG BRAM. Optional saturation via DOG_CLAMP_EN.

module dog_diff #(
    parameter int BIT_DEPTH = 8
) (
    input  logic [BIT_DEPTH-1:0] a,
    input  logic [BIT_DEPTH-1:0] b,
    output logic [BIT_DEPTH:0]   diff
);
    logic signed [BIT_DEPTH:0] raw;

    assign raw = $signed({1'b0, b}) - $signed({1'b0, a});

`ifdef DOG_CLAMP_EN
    localparam logic signed [BIT_DEPTH:0] SAT_HI = {2'b00, {(BIT_DEPTH-1){1'b1}}};
    localparam logic signed [BIT_DEPTH:0] SAT_LO = {2'b11, {(BIT_DEPTH-1){1'b0}}};

    always_comb begin
        diff = raw;
        if (raw > SAT_HI)
            diff = SAT_HI;
        else if (raw < SAT_LO)
            diff = SAT_LO;
    end
`else
    assign diff = raw;
`endif
endmodule

module dog_builder #(
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 64,
    parameter int BIT_DEPTH = 8,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [ADDR_W-1:0]    base_a_in,
    input  logic [ADDR_W-1:0]    base_b_in,
    input  logic [ADDR_W-1:0]    base_out_in,
    output logic [ADDR_W-1:0]    rd_addr_out,
    output logic                 rd_en_out,
    input  logic [BIT_DEPTH-1:0] rd_data_in,
    output logic [ADDR_W-1:0]    wr_addr_out,
    output logic [BIT_DEPTH:0]   wr_data_out,
    output logic                 wr_en_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out
);
    localparam int N     = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     base_a_q, base_b_q, base_o_q;
    logic [CNT_W-1:0]      rd_idx, wr_idx;
    logic                  rd_is_b;
    logic                  wr_last;
    logic [RD_LAT:1]       vld_pipe, tag_pipe;
    logic [BIT_DEPTH-1:0]  a_q;
    logic [BIT_DEPTH:0]    diff;
    logic                  accept;

    assign accept = (state == IDLE) && start_in;

    // Read issue FSM: alternates A/B addresses for each pixel, then waits for the last write.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_o_q    <= '0;
            rd_idx      <= '0;
            rd_is_b     <= 1'b0;
            rd_addr_out <= '0;
            rd_en_out   <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            error_out   <= 1'b0;
        end else begin
            error_out <= start_in && (state != IDLE);
            done_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        base_a_q    <= base_a_in;
                        base_b_q    <= base_b_in;
                        base_o_q    <= base_out_in;
                        rd_idx      <= '0;
                        rd_is_b     <= 1'b0;
                        rd_addr_out <= base_a_in;
                        rd_en_out   <= 1'b1;
                        busy_out    <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (!rd_is_b) begin
                        rd_addr_out <= base_b_q + ADDR_W'(rd_idx);
                        rd_is_b     <= 1'b1;
                    end else if (rd_idx == LAST) begin
                        rd_addr_out <= '0;
                        rd_en_out   <= 1'b0;
                        rd_is_b     <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        rd_idx      <= rd_idx + 1'b1;
                        rd_addr_out <= base_a_q + ADDR_W'(rd_idx + 1'b1);
                        rd_is_b     <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (wr_en_out && wr_last) begin
                        done_out <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dog_diff #(.BIT_DEPTH(BIT_DEPTH)) u_diff (
        .a    (a_q),
        .b    (rd_data_in),
        .diff (diff)
    );

    // Return path: tags follow each read through the BRAM latency; B returns trigger a write.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_pipe    <= '0;
            tag_pipe    <= '0;
            a_q         <= '0;
            wr_idx      <= '0;
            wr_last     <= 1'b0;
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[RD_LAT-1:1], rd_en_out};
            tag_pipe  <= {tag_pipe[RD_LAT-1:1], rd_is_b};
            wr_en_out <= 1'b0;
            wr_last   <= 1'b0;
            if (accept)
                wr_idx <= '0;
            else if (vld_pipe[RD_LAT]) begin
                if (!tag_pipe[RD_LAT]) begin
                    a_q <= rd_data_in;
                end else begin
                    wr_en_out   <= 1'b1;
                    wr_data_out <= diff;
                    wr_addr_out <= base_o_q + ADDR_W'(wr_idx);
                    wr_last     <= (wr_idx == LAST);
                    wr_idx      <= wr_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dog_builder.sv
// Directed bench for dog_builder at 4x4: timing, data, restart error, async abort, address wrap.

module tb_dog_builder;
    localparam int W = 4, H = 4, N = W * H;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start_in = 1'b0;
    logic [15:0] base_a_in = '0, base_b_in = '0, base_out_in = '0;
    logic [15:0] rd_addr_out, wr_addr_out;
    logic        rd_en_out, wr_en_out, busy_out, done_out, error_out;
    logic [7:0]  rd_data_in = '0;
    logic [8:0]  wr_data_out;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_s1 = '0;
    int          checks = 0, errors = 0;

    dog_builder #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8), .ADDR_W(16), .RD_LAT(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .base_a_in(base_a_in), .base_b_in(base_b_in), .base_out_in(base_out_in),
        .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
        .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle BRAM model
    always @(posedge clk_in) begin
        rd_s1      <= mem[rd_addr_out];
        rd_data_in <= rd_s1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_diff(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'(b) - int'(a);
`ifdef DOG_CLAMP_EN
        if (d > 127) d = 127;
        if (d < -128) d = -128;
`endif
        return d[8:0];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},   rd_en_out,   0);
        check({tag, "_rd_addr"}, rd_addr_out, 0);
        check({tag, "_wr_en"},   wr_en_out,   0);
        check({tag, "_wr_addr"}, wr_addr_out, 0);
        check({tag, "_wr_data"}, wr_data_out, 0);
        check({tag, "_busy"},    busy_out,    0);
        check({tag, "_done"},    done_out,    0);
        check({tag, "_error"},   error_out,   0);
    endtask

    // One full pass; cycle k is sampled at the negedge inside it. restart<0 means no second start.
    task automatic run_pass(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bo,
                            input int restart);
        logic [15:0] ea;
        logic        wexp;
        int          wi;
        base_a_in = ba; base_b_in = bb; base_out_in = bo;
        @(negedge clk_in);
        start_in = 1'b1;
        for (int k = 1; k <= 2*N + 6; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            if (k <= 2*N) begin
                ea = (k % 2 == 1) ? ba + 16'((k-1)/2) : bb + 16'((k-2)/2);
                check("rd_addr", rd_addr_out, ea);
                check("rd_en", rd_en_out, 1);
            end else begin
                check("rd_en_off", rd_en_out, 0);
            end
            wexp = (k >= 5) && (k <= 2*N + 3) && (k % 2 == 1);
            check("wr_en", wr_en_out, wexp);
            if (wexp) begin
                wi = (k - 5) / 2;
                check("wr_addr", wr_addr_out, bo + 16'(wi));
                check("wr_data", wr_data_out, exp_diff(mem[ba + 16'(wi)], mem[bb + 16'(wi)]));
            end
            check("done", done_out, k == 2*N + 4);
            check("busy", busy_out, k <= 2*N + 4);
            check("error", error_out, k == restart + 1);
            if (k == restart) start_in = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk_in);
        check_all_zero("reset");
        rst_in = 1'b1;
        @(negedge clk_in);

        // Uniform images: every write is 30-10 = 0x014
        for (int i = 0; i < N; i++) begin
            mem[i]      = 8'd10;
            mem[16 + i] = 8'd30;
        end
        run_pass(16'h0000, 16'h0010, 16'h0000, -1);

        // Mixed data including both extremes, plus a start while busy at cycle 10
        for (int i = 0; i < N; i++) begin
            mem[16'h0040 + i] = 8'((i * 17) & 255);
            mem[16'h0080 + i] = 8'((i * 29 + 3) & 255);
        end
        mem[16'h0040] = 8'd200; mem[16'h0080] = 8'd5;
        mem[16'h0041] = 8'd0;   mem[16'h0081] = 8'd255;
        mem[16'h0042] = 8'd255; mem[16'h0082] = 8'd0;
        run_pass(16'h0040, 16'h0080, 16'h0020, 10);

        // Async abort during cycle 12
        base_a_in = 16'h0000; base_b_in = 16'h0010; base_out_in = 16'h0000;
        @(negedge clk_in);
        start_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
        end
        #1 rst_in = 1'b0;
        #1 check_all_zero("abort");
        repeat (3) begin
            @(negedge clk_in);
            check("abort_wr_en", wr_en_out, 0);
            check("abort_rd_en", rd_en_out, 0);
            check("abort_busy", busy_out, 0);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        run_pass(16'h0000, 16'h0010, 16'h0000, -1);

        // Address wrap, and a start landing in the done cycle
        mem[16'hFFFE] = 8'd7; mem[16'hFFFF] = 8'd250;
        for (int i = 0; i < N; i++) mem[16'h0100 + i] = 8'((i * 41 + 9) & 255);
        run_pass(16'hFFFE, 16'h0100, 16'h0040, 2*N + 4);

        repeat (2) @(negedge clk_in);
        check("final_busy", busy_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dog_builder.md
Name: dog_builder

Overview:
- Downstream neighbour of the Gaussian pyramid stage.
- Once one octave's blurred images are in the pyramid BRAM, this block reads two adjacent blur levels pixel by pixel and writes their signed difference (Difference-of-Gaussians) to the DoG BRAM.
- It runs once per adjacent blur pair, started by the pyramid sequencer; the keypoint extrema stage consumes its output.

Parameters:
- WIDTH, 64, image width in pixels at the current octave
- HEIGHT, 64, image height in pixels
- BIT_DEPTH, 8, unsigned pixel width in the pyramid BRAM
- ADDR_W, 16, address width of the pyramid and DoG BRAMs
- RD_LAT, 2, pyramid BRAM read latency in cycles (fixed at 2)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- start_in  in  1  one-cycle request; sampled only in IDLE
- base_a_in  in  ADDR_W  base address of blur level k (finer)
- base_b_in  in  ADDR_W  base address of blur level k+1 (coarser)
- base_out_in  in  ADDR_W  base address of the DoG image in the DoG BRAM
- rd_addr_out  out  ADDR_W  pyramid BRAM read address
- rd_en_out  out  1  read enable
- rd_data_in  in  BIT_DEPTH  read data, valid RD_LAT cycles after rd_en_out
- wr_addr_out  out  ADDR_W  DoG BRAM write address
- wr_data_out  out  BIT_DEPTH+1  signed two's-complement difference
- wr_en_out  out  1  DoG write strobe
- busy_out  out  1  high while a pass is in progress
- done_out  out  1  one-cycle pulse on pass completion
- error_out  out  1  one-cycle pulse when start_in arrives while busy

Behaviour:
- Reset (rst_in low, asynchronous): FSM goes to IDLE; all outputs and counters are 0. A pass in flight is abandoned; there are no further reads or writes.
- Start: start_in and the three base inputs are latched in IDLE at cycle 0. The FSM enters RUN and busy_out rises at cycle 1.
- Definitions: N = WIDTH*HEIGHT; pixel index i runs from 0 to N-1 in raster order.
- Read stream, one pixel per 2 cycles:
  - Cycle 1+2i: rd_addr_out = base_a + i.
  - Cycle 2+2i: rd_addr_out = base_b + i.
  - rd_en_out is high on every RUN cycle.
- Address arithmetic is modulo 2^ADDR_W, so wrap-around is silent.
- Return tracking: a 2-deep tag shift register marks each issued read as A or B. An A return is held in a register. On the B return (cycle 4+2i), diff = {0,B} - {0,A} is computed at BIT_DEPTH+1 bits and registered.
- Write: at cycle 5+2i, wr_en_out = 1, wr_addr_out = base_out + i, wr_data_out = diff. wr_en_out is 0 otherwise.
- FSM states:
  - IDLE -> RUN on start_in.
  - RUN issues 2N reads, then -> DRAIN.
  - DRAIN waits for the final write (cycle 2N+3), then -> FIN.
  - FIN (cycle 2N+4): done_out = 1, busy_out still 1; then -> IDLE.
  - busy_out is 0 from cycle 2N+5.
- start_in in any state other than IDLE is ignored; error_out pulses for 1 cycle and the current pass is unaffected.
- start_in and done_out in the same cycle: start is ignored (FSM is in FIN) and error_out pulses.
- Extremes: B - A = +255 gives 0x0FF; B - A = -255 gives 0x101; no overflow is possible at BIT_DEPTH+1.
- rd_data_in is ignored whenever no tagged return is due.

Optional Feature:
- Macro: DOG_CLAMP_EN.
- Defined: diff is saturated to [-(2^(BIT_DEPTH-1)), 2^(BIT_DEPTH-1)-1], i.e. [-128, 127] for BIT_DEPTH=8. It is still sign-extended onto BIT_DEPTH+1 bits, and latency is unchanged.
- Undefined: full-range difference with no saturation logic.

Test Plan:
- WIDTH=HEIGHT=4, base_a=0, base_b=16, base_out=0, A all 10, B all 30, start at cycle 0:
  - 16 writes of 0x014 at addresses 0..15 on cycles 5, 7, ..., 35.
  - done_out at cycle 36; busy_out low at cycle 37.
- A=200, B=5 at pixel 0 -> wr_data_out = 0x13D (-195). With DOG_CLAMP_EN -> 0x180 (-128).
- A=0, B=255 -> 0x0FF. With DOG_CLAMP_EN -> 0x07F.
- start_in pulsed again at cycle 10 -> error_out high at cycle 11 only; write sequence and done timing are identical to the first scenario.
- rst_in low asynchronously at cycle 12 -> all outputs 0 immediately and no wr_en_out afterwards. A new start after release completes a full pass of 16 writes.
- base_a=0xFFFE, base_b=0x0100 -> rd_addr_out sequence 0xFFFE, 0x0100, 0xFFFF, 0x0101, 0x0000, 0x0102 (wrap).
